// File: rtl/input_debouncer.sv
// Debounces a bank of switches and five buttons against a slow sample tick.
// Buttons additionally produce press/release pulses, and every accepted
// change is queued as a 4-bit event code in a small FIFO for a consumer.
module input_debouncer #(
    parameter int BITS           = 16,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic [BITS-1:0] SW,
    input  logic            BTNC,
    input  logic            BTNU,
    input  logic            BTNL,
    input  logic            BTNR,
    input  logic            BTND,
    output logic [BITS-1:0] SW_DB,
    output logic [4:0]      BTN_DB,
    output logic [4:0]      BTN_PRESS,
    output logic [4:0]      BTN_RELEASE,
    output logic            EVT_VALID,
    input  logic            EVT_READY,
    output logic [3:0]      EVT_CODE,
    output logic            EVT_OVERFLOW
);
    timeunit 1ns;
    timeprecision 1ps;

    // Buttons occupy bits 0..4 of the combined input vector, switches follow.
    localparam int NIN = BITS + 5;
    localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] sync_meta;
    logic [NIN-1:0] sync_out;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic [STABLE_SAMPLES-1:0] hist      [NIN];
    logic [STABLE_SAMPLES-1:0] hist_next [NIN];
    logic [NIN-1:0] db;
    logic [NIN-1:0] db_next;
    logic [NIN-1:0] db_change;

    logic [4:0] press_q;
    logic [4:0] release_q;

    logic [5:0] pending;
    logic [5:0] new_events;
    logic [5:0] evt_dir;
    logic [5:0] drain_clear;
    logic       drain_valid;
    logic [3:0] drain_code;

    logic [3:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        overflow_q;

    assign raw_in = {SW, BTND, BTNR, BTNL, BTNU, BTNC};

    // Two-flop synchronizer on every raw input before any other use.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running sample divider; tick is high during the last count.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
        end
    end

    // Shifted history and acceptance: a level is taken only when every sample agrees.
    always_comb begin
        db_next = db;
        for (int i = 0; i < NIN; i++) begin
            hist_next[i] = {hist[i][STABLE_SAMPLES-2:0], sync_out[i]};
            if (tick && (&hist_next[i])) begin
                db_next[i] = 1'b1;
            end else if (tick && !(|hist_next[i])) begin
                db_next[i] = 1'b0;
            end
        end
        db_change = db_next ^ db;
    end

    // Sample histories and debounced levels advance only on the tick.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NIN; i++) begin
                hist[i] <= '0;
            end
            db <= '0;
        end else if (tick) begin
            for (int i = 0; i < NIN; i++) begin
                hist[i] <= hist_next[i];
            end
            db <= db_next;
        end
    end

    // Edge pulses line up with the first cycle the new debounced level is visible.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= db_change[4:0] & db_next[4:0];
            release_q <= db_change[4:0] & ~db_next[4:0];
        end
    end

    assign new_events = {|db_change[NIN-1:5], db_change[4:0]};
    assign evt_dir    = {1'b1, db[4:0]};

    // Pick the lowest pending source; its direction is the current debounced level.
    always_comb begin
        drain_valid = 1'b0;
        drain_clear = '0;
        drain_code  = '0;
        for (int i = 0; i < 6; i++) begin
            if (pending[i] && !drain_valid) begin
                drain_valid    = 1'b1;
                drain_clear[i] = 1'b1;
                drain_code     = {evt_dir[i], 3'(i)};
            end
        end
    end

    // Pending mask collects a tick's changes and loses one bit per drained event.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~drain_clear) | new_events;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && EVT_READY;
    assign push       = drain_valid && (!fifo_full || pop);
    assign drop       = drain_valid && fifo_full && !pop;

    // FIFO pointers carry an extra wrap bit; a dropped event latches the overflow flag.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Event storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= drain_code;
        end
    end

    assign SW_DB        = db[NIN-1:5];
    assign BTN_DB       = db[4:0];
    assign BTN_PRESS    = press_q;
    assign BTN_RELEASE  = release_q;
    assign EVT_VALID    = !fifo_empty;
    assign EVT_CODE     = fifo_empty ? 4'd0 : fifo_mem[rd_ptr[AW-1:0]];
    assign EVT_OVERFLOW = overflow_q;

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter BITS, default 16, switch vector width.
REQ-002 SHALL have parameter TICK_DIV, default 50000, clock cycles per sample tick; legal range 16..2^20.
REQ-003 SHALL have parameter STABLE_SAMPLES, default 3, consecutive equal tick samples needed to accept a new level; legal range 2..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two.
REQ-005 SHALL have port CLOCK, input, 1, the single clock.
REQ-006 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port SW, input, BITS, raw asynchronous switches.
REQ-008 SHALL have ports BTNC, BTNU, BTNL, BTNR, BTND, input, 1 each, raw asynchronous buttons; index 0..4 in that order.
REQ-009 SHALL have port SW_DB, output, BITS, debounced switches.
REQ-010 SHALL have port BTN_DB, output, 5, debounced button levels, bit n = button index n.
REQ-011 SHALL have port BTN_PRESS, output, 5, one-cycle pulse per debounced rising edge.
REQ-012 SHALL have port BTN_RELEASE, output, 5, one-cycle pulse per debounced falling edge.
REQ-013 SHALL have port EVT_VALID, output, 1, event FIFO non-empty.
REQ-014 SHALL have port EVT_READY, input, 1, consumer accepts the head event.
REQ-015 SHALL have port EVT_CODE, output, 4, head event: bit3 = 1 press / 0 release, bits2:0 = source index (0..4 buttons, 5 = any switch changed, bit3 = 1).
REQ-016 SHALL have port EVT_OVERFLOW, output, 1, sticky: an event was dropped.

Function
REQ-017 SHALL pass every raw input through a two-flop synchronizer before any other use.
REQ-018 SHALL count 0..TICK_DIV-1 and wrap to 0, producing a one-cycle tick on the count TICK_DIV-1.
REQ-019 SHALL, on each tick, shift each synchronized input into a per-input STABLE_SAMPLES-deep history register.
REQ-020 SHALL update a debounced bit at the tick edge where its full history is all-equal and differs from the current debounced value; it SHALL hold otherwise, including for a single-sample glitch.
REQ-021 SHALL assert BTN_PRESS[n] or BTN_RELEASE[n] for exactly the first cycle in which BTN_DB[n] shows its new value, with no additional pulse until the next accepted change.
REQ-022 SHALL OR button and switch changes accepted on the same tick into a 6-bit pending mask: buttons by index, bit 5 for any SW_DB change.
REQ-023 SHALL drain the pending mask into the FIFO at one entry per cycle, lowest index first, starting the cycle after the tick; TICK_DIV >= 16 guarantees the mask empties before the next tick.
REQ-024 SHALL present the FIFO head combinationally on EVT_CODE whenever EVT_VALID = 1; EVT_CODE SHALL be 0 when empty.
REQ-025 SHALL pop the head on any cycle with EVT_VALID & EVT_READY; a push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-026 SHALL discard the drained entry and set EVT_OVERFLOW when the FIFO is full and no pop occurs that cycle; EVT_OVERFLOW SHALL clear only on RESET.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-028 SHALL, while RESET = 1, asynchronously force SW_DB = 0, BTN_DB = 0, BTN_PRESS = 0, BTN_RELEASE = 0, EVT_VALID = 0, EVT_CODE = 0 and EVT_OVERFLOW = 0.
REQ-029 SHALL, while RESET = 1, clear the synchronizers, histories, tick counter, pending mask and FIFO pointers.
REQ-030 SHALL, on reset asserted mid-operation, discard pending and queued events and emit no pulse for any change accepted before reset.
REQ-031 SHALL, after RESET falls with inputs held at 1, produce the first edges and events as normal debounced 0->1 changes.

Verification (TICK_DIV = 16, STABLE_SAMPLES = 3, FIFO_DEPTH = 4)
REQ-032 SHALL cover: BTNC held at 1 from cycle 0 -> BTN_DB[0] rises at the third tick after synchronization; BTN_PRESS[0] high exactly 1 cycle; EVT_CODE = 4'b1000.
REQ-033 SHALL cover: BTNU high for 1 tick sample, then low -> BTN_DB[1], BTN_PRESS and EVT_VALID remain 0.
REQ-034 SHALL cover: BTNL, BTND and SW = 16'h0001 all accepted on the same tick, EVT_READY = 1 -> EVT_CODE sequence 4'b1010, 4'b1100, 4'b1101 on consecutive cycles.
REQ-035 SHALL cover: EVT_READY = 0 and 5 distinct press events -> 4 events held, EVT_OVERFLOW = 1; then drain 4 events and confirm EVT_VALID = 0 with EVT_OVERFLOW still 1.
REQ-036 SHALL cover: BTNR released (1->0) with EVT_READY = 1 -> BTN_RELEASE[3] 1-cycle pulse; EVT_CODE = 4'b0011.
REQ-037 SHALL cover: RESET pulsed for 1 ns while 2 events are queued -> all outputs 0 immediately; no events after release until new debounced changes occur.
